// File: rtl/ram_lsu_master.sv
// Load/store initiator for the data port of the dual-port RAM: word-addressed strobed writes, 1-cycle reads, lane-extracted responses.
// Optional macro RAM_LSU_BACK_TO_BACK_EN lets a new request be accepted in the cycle the previous response is consumed.
module ram_lsu_master #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [p_ADDR_BITS-1:0] req_addr,
  input  logic                   req_wr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [p_DATA_BITS-1:0] req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [p_DATA_BITS-1:0] resp_rdata,
  output logic                   resp_err,
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [p_STRB_BITS-1:0] mem_web,
  output logic [p_DATA_BITS-1:0] mem_wdata,
  input  logic [p_DATA_BITS-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t           state;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             issue_win;
  logic             accept;
  logic             legal;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [p_DATA_BITS-1:0] load_ext;

  // The request channel is open in IDLE, and also while a response is being consumed when back-to-back is enabled.
`ifdef RAM_LSU_BACK_TO_BACK_EN
  assign issue_win = (state == IDLE) || ((state == RESP) && resp_ready);
`else
  assign issue_win = (state == IDLE);
`endif

  assign req_ready = issue_win;
  assign accept    = req_valid && issue_win;

  always_comb begin
    legal = 1'b0;
    case (req_size)
      2'd0:    legal = 1'b1;
      2'd1:    legal = ~req_addr[0];
      2'd2:    legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_web   = '0;
    mem_wdata = '0;
    if (issue_win) begin
      mem_addr = {2'b00, req_addr[p_ADDR_BITS-1:2]};
      case (req_size)
        2'd0:    mem_wdata = {4{req_wdata[7:0]}};
        2'd1:    mem_wdata = {2{req_wdata[15:0]}};
        default: mem_wdata = req_wdata;
      endcase
      if (accept && legal) begin
        mem_ren = ~req_wr;
        mem_wen = req_wr;
        if (req_wr) begin
          case (req_size)
            2'd0:    mem_web = p_STRB_BITS'(4'b0001) << req_addr[1:0];
            2'd1:    mem_web = p_STRB_BITS'(4'b0011) << req_addr[1:0];
            default: mem_web = '1;
          endcase
        end
      end
    end
  end

  assign lane_byte = mem_q[{off_q, 3'b000} +: 8];
  assign lane_half = off_q[1] ? mem_q[31:16] : mem_q[15:0];

  always_comb begin
    load_ext = mem_q;
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & lane_byte[7]}}, lane_byte};
      2'd1:    load_ext = {{16{~uns_q & lane_half[15]}}, lane_half};
      default: load_ext = mem_q;
    endcase
  end

  // A new acceptance (possible in RESP only with back-to-back) overrides the return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
    end else begin
      case (state)
        RD_WAIT: begin
          resp_rdata <= load_ext;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        default: begin
          if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
          if (accept) begin
            if (!legal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_wr) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              off_q  <= req_addr[1:0];
              size_q <= req_size;
              uns_q  <= req_unsigned;
              state  <= RD_WAIT;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu_master.sv
// Directed testbench for ram_lsu_master with a byte-strobed RAM model and a response scoreboard.
module tb_ram_lsu_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [3:0]  mem_web;
  logic [31:0] mem_wdata;
  logic [31:0] mem_q;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ram [0:15];

  ram_lsu_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_web(mem_web), .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // RAM model: strobed writes, read data registered one cycle after mem_ren and held otherwise.
  always @(posedge clk) begin
    if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_web[b]) ram[mem_addr[3:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (mem_ren) mem_q <= ram[mem_addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check({tag, "_ren_idle"}, {31'b0, mem_ren}, 32'd0);
      check({tag, "_wen_idle"}, {31'b0, mem_wen}, 32'd0);
    end while (!resp_valid && n < 8);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_timeout"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_latency"}, n, e.lat);
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
    if (hold > 0) begin
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h0000_0020;
      req_wdata = 32'hDEAD_BEEF;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_hold_rdata"}, resp_rdata, e.rdata);
        check({tag, "_hold_err"}, {31'b0, resp_err}, {31'b0, e.err});
        check({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
        check({tag, "_hold_ren"}, {31'b0, mem_ren}, 32'd0);
        check({tag, "_hold_wen"}, {31'b0, mem_wen}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_consumed"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr,
                               input logic [3:0] expWeb, input logic [31:0] expWdata,
                               input int hold);
    logic legal;
    exp_t e;
    legal = (size == 2'd0) || (size == 2'd1 && !addr[0]) || (size == 2'd2 && addr[1:0] == 2'b00);
    @(negedge clk);
    req_valid    = 1'b1;
    req_wr       = wr;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = 1'b1;
    #1;
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_mem_ren"}, {31'b0, mem_ren}, {31'b0, legal && !wr});
    check({tag, "_mem_wen"}, {31'b0, mem_wen}, {31'b0, legal && wr});
    check({tag, "_mem_web"}, {28'b0, mem_web}, {28'b0, expWeb});
    if (legal) check({tag, "_mem_addr"}, mem_addr, addr >> 2);
    if (legal && wr) check({tag, "_mem_wdata"}, mem_wdata, expWdata);
    e.rdata = expRdata;
    e.err   = expErr;
    e.lat   = (legal && !wr) ? 2 : 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = (hold == 0);
    checkOutput(tag, hold);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    mem_q        = 32'h0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_wr       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    $display("[TB] word round trip");
    applyStimulus("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 4'hF, 32'h1122_3344, 0);
    applyStimulus("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 4'h0, 32'h0, 0);

    $display("[TB] byte lanes");
    applyStimulus("st_b13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 0);
    applyStimulus("ld_bs13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFA5, 1'b0, 4'h0, 32'h0, 0);
    applyStimulus("ld_bu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0000_00A5, 1'b0, 4'h0, 32'h0, 0);
    applyStimulus("ld_w10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hA522_3344, 1'b0, 4'h0, 32'h0, 0);

    $display("[TB] half lanes");
    applyStimulus("st_w10h", 1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_1234, 32'h0, 1'b0, 4'hF, 32'h8001_1234, 0);
    applyStimulus("ld_hs12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0, 4'h0, 32'h0, 0);
    applyStimulus("ld_hu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1'b0, 4'h0, 32'h0, 0);
    applyStimulus("ld_hs10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h0000_1234, 1'b0, 4'h0, 32'h0, 0);
    applyStimulus("ld_bu11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h0000_0012, 1'b0, 4'h0, 32'h0, 0);
    applyStimulus("ld_bs10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0000_0034, 1'b0, 4'h0, 32'h0, 0);
    applyStimulus("st_h16", 1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 0);
    applyStimulus("ld_w14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'hBEEF_0000, 1'b0, 4'h0, 32'h0, 0);

    $display("[TB] errors");
    applyStimulus("err_w06", 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0);
    applyStimulus("err_h03", 1'b1, 2'd1, 1'b0, 32'h03, 32'h1234_5678, 32'h0, 1'b1, 4'h0, 32'h0, 0);
    applyStimulus("err_s3", 1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0);
    applyStimulus("ld_w14_after_err", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'hBEEF_0000, 1'b0, 4'h0, 32'h0, 0);

    $display("[TB] backpressure");
    applyStimulus("bp_ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_1234, 1'b0, 4'h0, 32'h0, 5);
    check("bp_store_ignored", ram[8], 32'h0);

    $display("[TB] reset in RD_WAIT");
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("ld_w10_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_1234, 1'b0, 4'h0, 32'h0, 0);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_lsu_master.md
Name: ram_lsu_master

Overview:
- Initiator for the RAM read/write port (data side) of the dual-port RAM.
- Accepts load/store requests from the core pipeline on a valid/ready request channel.
- Drives the RAM's word-addressed port with byte strobes and 1-cycle registered read data.
- Returns lane-extracted, sign/zero-extended load data on a valid/ready response channel, and flags misaligned or illegal accesses.

Parameters:
p_ADDR_BITS, 32, byte-address width of req_addr and word-address width of mem_addr
p_DATA_BITS, 32, data width; only 32 is supported
p_STRB_BITS, p_DATA_BITS/8, byte-strobe width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  p_ADDR_BITS  byte address
req_wr  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_wdata  in  p_DATA_BITS  store data, right-aligned
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  p_DATA_BITS  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal access
mem_addr  out  p_ADDR_BITS  word address = zero-extended req_addr[p_ADDR_BITS-1:2]
mem_ren  out  1  RAM read enable
mem_wen  out  1  RAM write enable
mem_web  out  p_STRB_BITS  per-byte write enables
mem_wdata  out  p_DATA_BITS  lane-replicated store data
mem_q  in  p_DATA_BITS  RAM read data; valid 1 cycle after mem_ren, held otherwise

Behaviour:
- FSM states: IDLE, RD_WAIT, RESP. Reset puts the FSM in IDLE.
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0. The captured offset, size and unsigned registers reset to 0.
- RAM outputs are combinational from the request channel in IDLE and 0 in every other state:
  - mem_addr is 0 outside IDLE.
  - In IDLE, mem_ren/mem_wen/mem_web are asserted only on an accepted, legal request.
- req_ready = (state==IDLE).
- Legality:
  - half is misaligned if addr[0]=1.
  - word is misaligned if addr[1:0]!=0.
  - size 3 is always illegal.
  - An illegal access never asserts mem_ren or mem_wen.
- IDLE, accepted illegal request: go to RESP with resp_err=1, resp_rdata=0.
- IDLE, accepted legal store:
  - mem_wen=1 in the same cycle.
  - mem_web = 4'b0001<<addr[1:0] (byte), 4'b0011<<addr[1:0] (half), 4'hF (word).
  - mem_wdata = byte replicated x4, half replicated x2, or word unchanged.
  - Go to RESP with resp_err=0, resp_rdata=0.
- IDLE, accepted legal load: mem_ren=1; capture addr[1:0], size and unsigned; go to RD_WAIT.
- RD_WAIT:
  - Select the byte at offset*8 or the half at offset[1]*16 from mem_q, or the full word.
  - Extend per the captured unsigned bit and register the result into resp_rdata.
  - Go to RESP.
- RESP: resp_valid=1. Outputs stay stable until resp_ready=1, then return to IDLE.
- Latency, acceptance edge to resp_valid high: loads 2 cycles; stores and errors 1 cycle. Throughput is one request per 3 cycles (load) or 2 cycles (store), with resp_ready tied high.
- Reset mid-operation: the FSM returns to IDLE immediately and any pending response is dropped. A store already issued to the RAM is not undone.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: RAM_LSU_BACK_TO_BACK_EN.
- With the macro defined:
  - In RESP, req_ready = resp_ready.
  - A request arriving in the same cycle the response is consumed is handled as if in IDLE: it drives the RAM and goes directly to RD_WAIT or RESP.
  - Throughput becomes 1 store/cycle or 1 load per 2 cycles.
- Without the macro: behaviour is exactly as in Behaviour (req_ready only in IDLE).

Test Plan:
- Word round trip: store 0x11223344 at 0x10 -> mem_addr=0x4, mem_web=4'hF, resp 1 cycle later. Then load word at 0x10 -> resp_rdata=0x11223344 exactly 2 cycles after acceptance, resp_err=0.
- Byte lanes: store byte 0xA5 at 0x13 -> mem_web=4'b1000, mem_wdata=0xA5A5A5A5. Signed byte load at 0x13 -> 0xFFFFFFA5. Unsigned byte load -> 0x000000A5.
- Half lanes: RAM word 0x8001_1234 at 0x12. Signed half load at 0x12 -> 0xFFFF8001. Unsigned half load -> 0x00008001. Half load at 0x10 -> 0x00001234.
- Errors: word load at 0x06, half store at 0x03, size=3 at 0x00 -> each gives resp_err=1, resp_rdata=0, mem_ren=mem_wen=0 throughout.
- Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid, resp_rdata and resp_err stable, req_ready=0, no RAM enables. With RAM_LSU_BACK_TO_BACK_EN, a new request presented with resp_ready=1 is accepted in that same cycle.
- Reset in RD_WAIT: assert reset asynchronously -> resp_valid=0, req_ready=1 without waiting for a clock edge. A following word load returns correct data.
